reservation_station: RTL and testbench
======================================

# reservation_station

Receiving end of the Issue unit's RS dispatch path in the Tomasulo core. It buffers non-load/store instructions with their renamed operands (Q tag / V value) and snoops both CDB broadcasts to resolve pending tags. Each cycle it dispatches at most one instruction whose operands are both ready to the ALU. It reports `full` back so the Issue unit and InsFetcher stall.

## Interface
- `RS_SIZE`, 8, number of entries (power of two, 2..16)
- `ROB_W`, 4, ROB tag width; tag 0 = "no dependency", the ROB allocates 1..2^ROB_W-1
- `OP_W`, 6, opcode-type width
- `clk` in 1 — the single clock; all state changes on its rising edge
- `rst` in 1 — reset, asynchronous and active-low
- `rdy` in 1 — global run enable; low = pause
- `flush` in 1 — ROB mispredict clear, synchronous
- `issue_ena` in 1 — issue request from the Issue unit
- `issue_op` in OP_W — opcode type
- `issue_Qi`, `issue_Qj` in ROB_W — source tags; 0 = value valid
- `issue_Vi`, `issue_Vj` in 32 — source values, meaningful when the tag is 0
- `issue_imm`, `issue_pc` in 32 — immediate and instruction PC
- `issue_rob_id` in ROB_W — destination ROB tag
- `full` out 1 — no free entry
- `cdb0_valid`, `cdb1_valid` in 1 — ALU CDB and LSB CDB broadcast valid
- `cdb0_rob_id`, `cdb1_rob_id` in ROB_W — broadcast tags
- `cdb0_value`, `cdb1_value` in 32 — broadcast results
- `alu_ena` out 1 — one-cycle dispatch pulse
- `alu_op` out OP_W; `alu_Vi`, `alu_Vj`, `alu_imm`, `alu_pc` out 32; `alu_rob_id` out ROB_W — dispatch payload, registered

## Operation
- Each entry holds: busy, op, Qi, Qj, Vi, Vj, imm, pc, rob_id.
- A ready entry is one that is busy with Qi==0 and Qj==0.
- Issue: when `issue_ena` and !`full`, write the lowest-index non-busy entry and set busy.
  - Issue while `full` is a protocol violation: it is ignored and no entry changes.
- Issue-time bypass: if an incoming Qi (or Qj) is nonzero and equals a valid CDB tag in the same cycle, store Q=0 and V=the CDB value.
  - cdb0 wins if both CDBs match.
- CDB snoop: for every busy entry and each operand with Q≠0 matching a valid CDB tag, set Q=0 and V=the CDB value.
  - Both operands may resolve in the same cycle.
  - cdb0 has priority when both CDBs carry the same tag, which the ROB never produces.
- Dispatch: among the entries ready at the start of the cycle, pick the lowest index.
  - Register its payload onto the `alu_*` outputs and pulse `alu_ena`=1.
  - Clear its busy bit at the same edge.
  - No ready entry: `alu_ena`=0 and the payload holds its last value.
- Operand wake-up is not forwarded into the dispatch select. An entry resolved by a CDB this cycle becomes ready next cycle.
- `full` is combinational: AND of all busy bits in current state. Same-cycle dispatch does not lower `full`.
- Priority per edge: async `rst` > `flush` > `!rdy` > normal operation.
  - `flush`: all busy bits cleared, `alu_ena`=0, issue and CDB ignored.
  - `!rdy`: all entry state frozen, `alu_ena` forced 0, inputs ignored.
- Arithmetic: none on data. Only tag equality compares (ROB_W bits) and a priority encoder over busy/ready bits.

## Timing
- Reset (`rst`=0, async): all busy bits=0; `alu_ena`=0; `alu_op`, `alu_Vi`, `alu_Vj`, `alu_imm`, `alu_pc`, `alu_rob_id`=0; `full`=0. Entry payload contents are don't-care.
- Issue-to-dispatch latency:
  - operands ready at issue: issued at edge N, `alu_ena` high after edge N+1, so minimum 2 cycles from `issue_ena` sampled to `alu_ena` visible.
  - waiting operand: a CDB broadcast at edge M gives `alu_ena` after edge M+1 at the earliest.
- `alu_ena` is high for exactly one cycle per instruction and never repeats the same entry.
- Issue and dispatch may occur in the same cycle. When full, a dispatch frees an entry that is visible as `full`=0 the next cycle.
- `rst` deasserted mid-operation: the first active edge behaves as from an empty station.
- Pause: entry state is bit-identical before and after any number of `rdy`=0 cycles.

## Test plan
- Reset, then issue op=3, Qi=Qj=0, Vi=5, Vj=7, rob_id=2 -> two cycles later `alu_ena`=1 for 1 cycle with Vi=5, Vj=7, rob_id=2.
- Issue Qi=4, Vj=9; three cycles later cdb1 tag 4 value 0x1234 -> `alu_ena` the next cycle with Vi=0x1234, Vj=9.
- Issue Qi=6 while cdb0 broadcasts tag 6 value 0xAA in the same cycle -> dispatched after the minimum latency with Vi=0xAA.
- Issue 8 entries with Qi=5 -> `full`=1 and a ninth issue is ignored; cdb0 tag 5 -> 8 pulses on consecutive cycles in rob_id order of entries 0..7, and `full` drops one cycle after the first dispatch.
- 4 entries waiting, `flush` pulse -> `full`=0 and no `alu_ena`, even when their tags broadcast afterward.
- Ready entry present, hold `rdy`=0 for 5 cycles -> `alu_ena` stays 0; after `rdy`=1 exactly one pulse with the correct payload. Async `rst` during a CDB cycle -> outputs zero immediately.

Source files
------------

// File: rtl/reservation_station.sv
// Reservation station for non-memory ops: holds renamed operands, snoops both
// CDBs, and dispatches the lowest-index ready entry to the ALU each cycle.
module reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             issue_ena,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [ROB_W-1:0] issue_Qi,
  input  logic [ROB_W-1:0] issue_Qj,
  input  logic [31:0]      issue_Vi,
  input  logic [31:0]      issue_Vj,
  input  logic [31:0]      issue_imm,
  input  logic [31:0]      issue_pc,
  input  logic [ROB_W-1:0] issue_rob_id,
  output logic             full,
  input  logic             cdb0_valid,
  input  logic [ROB_W-1:0] cdb0_rob_id,
  input  logic [31:0]      cdb0_value,
  input  logic             cdb1_valid,
  input  logic [ROB_W-1:0] cdb1_rob_id,
  input  logic [31:0]      cdb1_value,
  output logic             alu_ena,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_Vi,
  output logic [31:0]      alu_Vj,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [ROB_W-1:0] alu_rob_id
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy;
  logic [OP_W-1:0]    op_q  [RS_SIZE];
  logic [ROB_W-1:0]   qi_q  [RS_SIZE];
  logic [ROB_W-1:0]   qj_q  [RS_SIZE];
  logic [31:0]        vi_q  [RS_SIZE];
  logic [31:0]        vj_q  [RS_SIZE];
  logic [31:0]        imm_q [RS_SIZE];
  logic [31:0]        pc_q  [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];

  logic             disp_valid;
  logic [IDX_W-1:0] disp_idx;
  logic [IDX_W-1:0] free_idx;
  logic             run;
  logic             do_issue;

  // Downward scan so the last hit written is the lowest index.
  always_comb begin
    disp_valid = 1'b0;
    disp_idx   = '0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (busy[i] && qi_q[i] == '0 && qj_q[i] == '0) begin
        disp_valid = 1'b1;
        disp_idx   = IDX_W'(i);
      end
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  assign full     = &busy;
  assign run      = rdy && !flush;
  assign do_issue = run && issue_ena && !full;

  // Returns {tag, value} after a CDB match; cdb0 overrides cdb1.
  function automatic logic [ROB_W+31:0] resolve(input logic [ROB_W-1:0] q,
                                                input logic [31:0] v);
    logic [ROB_W+31:0] r;
    r = {q, v};
    if (q != '0 && cdb1_valid && cdb1_rob_id == q) r = {{ROB_W{1'b0}}, cdb1_value};
    if (q != '0 && cdb0_valid && cdb0_rob_id == q) r = {{ROB_W{1'b0}}, cdb0_value};
    return r;
  endfunction

  // Payload storage needs no reset: busy alone decides whether an entry is live.
  always_ff @(posedge clk) begin
    if (run) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          {qi_q[i], vi_q[i]} <= resolve(qi_q[i], vi_q[i]);
          {qj_q[i], vj_q[i]} <= resolve(qj_q[i], vj_q[i]);
        end
      end
      if (do_issue) begin
        op_q[free_idx]                   <= issue_op;
        imm_q[free_idx]                  <= issue_imm;
        pc_q[free_idx]                   <= issue_pc;
        rob_q[free_idx]                  <= issue_rob_id;
        {qi_q[free_idx], vi_q[free_idx]} <= resolve(issue_Qi, issue_Vi);
        {qj_q[free_idx], vj_q[free_idx]} <= resolve(issue_Qj, issue_Vj);
      end
    end
  end

  // Issue targets a free entry and dispatch a busy one, so they never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      alu_ena    <= 1'b0;
      alu_op     <= '0;
      alu_Vi     <= '0;
      alu_Vj     <= '0;
      alu_imm    <= '0;
      alu_pc     <= '0;
      alu_rob_id <= '0;
    end else if (flush) begin
      busy    <= '0;
      alu_ena <= 1'b0;
    end else if (!rdy) begin
      alu_ena <= 1'b0;
    end else begin
      alu_ena <= disp_valid;
      if (disp_valid) begin
        alu_op         <= op_q[disp_idx];
        alu_Vi         <= vi_q[disp_idx];
        alu_Vj         <= vj_q[disp_idx];
        alu_imm        <= imm_q[disp_idx];
        alu_pc         <= pc_q[disp_idx];
        alu_rob_id     <= rob_q[disp_idx];
        busy[disp_idx] <= 1'b0;
      end
      if (do_issue) busy[free_idx] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_reservation_station;
  localparam int N  = 8;
  localparam int PW = 6 + 32 * 4 + 4;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, issue_ena;
  logic [5:0]  issue_op;
  logic [3:0]  issue_Qi, issue_Qj, issue_rob_id;
  logic [31:0] issue_Vi, issue_Vj, issue_imm, issue_pc;
  logic        full;
  logic        cdb0_valid, cdb1_valid;
  logic [3:0]  cdb0_rob_id, cdb1_rob_id;
  logic [31:0] cdb0_value, cdb1_value;
  logic        alu_ena;
  logic [5:0]  alu_op;
  logic [31:0] alu_Vi, alu_Vj, alu_imm, alu_pc;
  logic [3:0]  alu_rob_id;

  reservation_station #(.RS_SIZE(N), .ROB_W(4), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_ena(issue_ena), .issue_op(issue_op), .issue_Qi(issue_Qi), .issue_Qj(issue_Qj),
    .issue_Vi(issue_Vi), .issue_Vj(issue_Vj), .issue_imm(issue_imm), .issue_pc(issue_pc),
    .issue_rob_id(issue_rob_id), .full(full),
    .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_value(cdb1_value),
    .alu_ena(alu_ena), .alu_op(alu_op), .alu_Vi(alu_Vi), .alu_Vj(alu_Vj),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_id(alu_rob_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural model
  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [3:0]  qi, qj, rob;
    logic [31:0] vi, vj, imm, pc;
  } ent_t;

  ent_t            m [N];
  bit              m_ena;
  logic [PW-1:0]   m_pay;
  logic [PW-1:0]   exp_q[$];
  int              checks = 0;
  int              errors = 0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i].busy = 0;
    m_ena = 0;
    m_pay = '0;
    exp_q.delete();
  endtask

  task automatic cdb_lookup(input logic [3:0] q_in, input logic [31:0] v_in,
                            output logic [3:0] q_out, output logic [31:0] v_out);
    q_out = q_in;
    v_out = v_in;
    if (q_in != 4'd0) begin
      if (cdb0_valid && cdb0_rob_id == q_in) begin q_out = 0; v_out = cdb0_value; end
      else if (cdb1_valid && cdb1_rob_id == q_in) begin q_out = 0; v_out = cdb1_value; end
    end
  endtask

  task automatic model_step();
    int d, f;
    bit was_full;
    if (flush) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      m_ena = 0;
      return;
    end
    if (!rdy) begin
      m_ena = 0;
      return;
    end
    d = -1; f = -1; was_full = 1;
    for (int i = 0; i < N; i++) begin
      if (d < 0 && m[i].busy && m[i].qi == 0 && m[i].qj == 0) d = i;
      if (f < 0 && !m[i].busy) f = i;
      if (!m[i].busy) was_full = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy) begin
        cdb_lookup(m[i].qi, m[i].vi, m[i].qi, m[i].vi);
        cdb_lookup(m[i].qj, m[i].vj, m[i].qj, m[i].vj);
      end
    end
    if (d >= 0) begin
      m_ena = 1;
      m_pay = {m[d].op, m[d].vi, m[d].vj, m[d].imm, m[d].pc, m[d].rob};
      m[d].busy = 0;
      exp_q.push_back(m_pay);
    end else begin
      m_ena = 0;
    end
    if (issue_ena && !was_full) begin
      m[f].busy = 1;
      m[f].op   = issue_op;
      m[f].imm  = issue_imm;
      m[f].pc   = issue_pc;
      m[f].rob  = issue_rob_id;
      cdb_lookup(issue_Qi, issue_Vi, m[f].qi, m[f].vi);
      cdb_lookup(issue_Qj, issue_Vj, m[f].qj, m[f].vj);
    end
  endtask

  function automatic bit model_full();
    bit r = 1;
    for (int i = 0; i < N; i++) if (!m[i].busy) r = 0;
    return r;
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare();
    logic [PW-1:0] pay, e;
    pay = {alu_op, alu_Vi, alu_Vj, alu_imm, alu_pc, alu_rob_id};
    check("full", PW'(full), PW'(model_full()));
    check("alu_ena", PW'(alu_ena), PW'(m_ena));
    check("payload", pay, m_pay);
    if (alu_ena) begin
      if (exp_q.size() == 0) begin
        check("unexpected_dispatch", PW'(1), PW'(0));
      end else begin
        e = exp_q.pop_front();
        check("dispatch_order", pay, e);
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_idle();
    rdy = 1; flush = 0; issue_ena = 0;
    issue_op = 0; issue_Qi = 0; issue_Qj = 0; issue_Vi = 0; issue_Vj = 0;
    issue_imm = 0; issue_pc = 0; issue_rob_id = 0;
    cdb0_valid = 0; cdb0_rob_id = 0; cdb0_value = 0;
    cdb1_valid = 0; cdb1_rob_id = 0; cdb1_value = 0;
  endtask

  task automatic set_issue(input logic [5:0] op, input logic [3:0] qi, input logic [31:0] vi,
                           input logic [3:0] qj, input logic [31:0] vj, input logic [3:0] rob);
    issue_ena = 1; issue_op = op; issue_Qi = qi; issue_Vi = vi; issue_Qj = qj; issue_Vj = vj;
    issue_imm = 32'h100 + rob; issue_pc = 32'h4000 + {rob, 2'b00}; issue_rob_id = rob;
  endtask

  task automatic random_inputs();
    set_idle();
    rdy   = ($urandom_range(0, 7) != 0);
    flush = ($urandom_range(0, 49) == 0);
    if ($urandom_range(0, 1) == 1)
      set_issue(6'($urandom_range(0, 63)),
                ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 7)) : 4'd0, $urandom,
                ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 7)) : 4'd0, $urandom,
                4'($urandom_range(1, 15)));
    cdb0_valid = ($urandom_range(0, 9) < 4);
    cdb0_rob_id = 4'($urandom_range(1, 7));
    cdb0_value = $urandom;
    cdb1_valid = ($urandom_range(0, 9) < 4);
    cdb1_rob_id = 4'($urandom_range(1, 7));
    cdb1_value = $urandom;
  endtask

  initial begin
    rst = 0;
    set_idle();
    model_reset();
    tick();
    check("rst_full", PW'(full), PW'(0));
    check("rst_ena", PW'(alu_ena), PW'(0));
    check("rst_rob", PW'(alu_rob_id), PW'(0));
    rst = 1;
    tick();

    // operands ready at issue: pulse two cycles after issue request
    set_issue(6'd3, 4'd0, 32'd5, 4'd0, 32'd7, 4'd2);
    tick();
    check("t1_early", PW'(alu_ena), PW'(0));
    set_idle();
    tick();
    check("t1_ena", PW'(alu_ena), PW'(1));
    check("t1_vi", PW'(alu_Vi), PW'(5));
    check("t1_vj", PW'(alu_Vj), PW'(7));
    check("t1_rob", PW'(alu_rob_id), PW'(2));
    check("t1_op", PW'(alu_op), PW'(3));
    tick();
    check("t1_one_pulse", PW'(alu_ena), PW'(0));

    // waiting operand woken by cdb1
    set_issue(6'd1, 4'd4, 32'd0, 4'd0, 32'd9, 4'd3);
    tick();
    set_idle();
    tick();
    tick();
    cdb1_valid = 1; cdb1_rob_id = 4'd4; cdb1_value = 32'h1234;
    tick();
    check("t2_wait", PW'(alu_ena), PW'(0));
    set_idle();
    tick();
    check("t2_ena", PW'(alu_ena), PW'(1));
    check("t2_vi", PW'(alu_Vi), PW'(32'h1234));
    check("t2_vj", PW'(alu_Vj), PW'(9));

    // issue-time bypass from cdb0
    set_issue(6'd2, 4'd6, 32'd0, 4'd0, 32'd1, 4'd5);
    cdb0_valid = 1; cdb0_rob_id = 4'd6; cdb0_value = 32'hAA;
    tick();
    set_idle();
    tick();
    check("t3_ena", PW'(alu_ena), PW'(1));
    check("t3_vi", PW'(alu_Vi), PW'(32'hAA));

    // fill, overflow ignored, drain in entry order
    for (int k = 0; k < N; k++) begin
      set_issue(6'd4, 4'd5, 32'd0, 4'd0, 32'(k), 4'(k + 1));
      tick();
    end
    check("t4_full", PW'(full), PW'(1));
    set_issue(6'd4, 4'd5, 32'd0, 4'd0, 32'd99, 4'd9);
    tick();
    check("t4_still_full", PW'(full), PW'(1));
    set_idle();
    cdb0_valid = 1; cdb0_rob_id = 4'd5; cdb0_value = 32'h55;
    tick();
    check("t4_wake_no_ena", PW'(alu_ena), PW'(0));
    set_idle();
    tick();
    check("t4_first_rob", PW'(alu_rob_id), PW'(1));
    check("t4_full_drop", PW'(full), PW'(0));
    for (int k = 1; k < N; k++) begin
      tick();
      check("t4_drain_ena", PW'(alu_ena), PW'(1));
      check("t4_drain_rob", PW'(alu_rob_id), PW'(k + 1));
    end
    tick();
    check("t4_no_ninth", PW'(alu_ena), PW'(0));

    // flush discards waiting entries
    for (int k = 0; k < 4; k++) begin
      set_issue(6'd5, 4'd7, 32'd0, 4'd0, 32'd0, 4'(k + 1));
      tick();
    end
    set_idle();
    flush = 1;
    tick();
    check("t5_full", PW'(full), PW'(0));
    set_idle();
    cdb0_valid = 1; cdb0_rob_id = 4'd7; cdb0_value = 32'h77;
    tick();
    set_idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_no_ena", PW'(alu_ena), PW'(0));
    end

    // pause holds a ready entry
    set_issue(6'd6, 4'd0, 32'h11, 4'd0, 32'h22, 4'd6);
    tick();
    set_idle();
    rdy = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_paused", PW'(alu_ena), PW'(0));
    end
    rdy = 1;
    tick();
    check("t6_ena", PW'(alu_ena), PW'(1));
    check("t6_vi", PW'(alu_Vi), PW'(32'h11));
    check("t6_rob", PW'(alu_rob_id), PW'(6));
    tick();
    check("t6_one_pulse", PW'(alu_ena), PW'(0));

    // async reset during a CDB cycle
    set_issue(6'd7, 4'd3, 32'd0, 4'd0, 32'd0, 4'd7);
    tick();
    set_idle();
    cdb0_valid = 1; cdb0_rob_id = 4'd3; cdb0_value = 32'h33;
    #2 rst = 0;
    #1;
    model_reset();
    check("t7_rob_zero", PW'(alu_rob_id), PW'(0));
    check("t7_vi_zero", PW'(alu_Vi), PW'(0));
    check("t7_full", PW'(full), PW'(0));
    tick();
    rst = 1;
    tick();
    check("t7_empty_after", PW'(alu_ena), PW'(0));
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      random_inputs();
      tick();
    end
    set_idle();
    for (int c = 0; c < 40; c++) begin
      cdb0_valid = 1; cdb0_rob_id = 4'(1 + (c % 7)); cdb0_value = 32'(c);
      tick();
    end
    set_idle();
    flush = 1;
    tick();
    set_idle();
    tick();
    check("queue_drained", PW'(exp_q.size()), PW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
